mem_bus_bridge_ts: RTL

- Downstream memory stage for the LEGv8 tri-state CPU.
- Decodes CPU word addresses against a local window and turns CPU mem_read/mem_write strobes into single-cycle requests to a synchronous single-port RAM with fixed read latency.
- Returns read data on the shared 64-bit tri-state data bus, with a ready handshake so the CPU control unit can stall.

---
 rtl/mem_bus_bridge_ts_if.sv | 17 +
 rtl/mem_bus_bridge_ts.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge_ts_if.sv
// CPU-side handshake bundle for mem_bus_bridge_ts (address and request/ready strobes).
// align_err exists only when MEM_BUS_BRIDGE_ALIGN_ERR_EN is defined.
interface mem_bus_bridge_ts_if;
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready;
`ifdef MEM_BUS_BRIDGE_ALIGN_ERR_EN
    logic        align_err;

    modport master (output address, mem_read, mem_write, input mem_ready, align_err);
    modport slave  (input address, mem_read, mem_write, output mem_ready, align_err);
`else
    modport master (output address, mem_read, mem_write, input mem_ready);
    modport slave  (input address, mem_read, mem_write, output mem_ready);
`endif
endinterface

// File: rtl/mem_bus_bridge_ts.sv
// LEGv8 tri-state bus to synchronous single-port RAM bridge with fixed read latency.
// Optional misaligned-access reporting: define MEM_BUS_BRIDGE_ALIGN_ERR_EN.
module mem_bus_bridge_ts #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_bus_bridge_ts_if.slave    cpu,
    inout  wire  [63:0]           data,
    output logic [ADDR_BITS-1:0]  ram_addr,
    output logic [63:0]           ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [63:0]           ram_rdata
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned LAT_W  = 3;
    localparam logic [32:0] WIN_BYTES = 33'(64'd8 << ADDR_BITS);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_DONE} state_t;

    state_t               state, state_d;
    logic [LAT_W-1:0]     lat_cnt, lat_cnt_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [ADDR_BITS-1:0] ram_addr_d;
    logic [DATA_W-1:0]    ram_wdata_d;
    logic                 ram_we_d, ram_re_d;
    logic                 mem_ready_q, mem_ready_d;

    logic [31:0]          offset_c;
    logic                 hit_c;
    logic [ADDR_BITS-1:0] word_c;
    logic                 data_oe_c;

    // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
    assign offset_c = cpu.address - BASE_ADDR;
    assign hit_c    = {1'b0, offset_c} < WIN_BYTES;
    assign word_c   = offset_c[ADDR_BITS+2:3];

`ifdef MEM_BUS_BRIDGE_ALIGN_ERR_EN
    logic align_err_q, align_err_d;
    logic misalign_c;
    assign misalign_c    = cpu.address[2:0] != 3'd0;
    assign cpu.align_err = align_err_q;
`endif

    // Bus is released in the same cycle the CPU drops mem_read.
    assign data_oe_c     = (state == RD_DRIVE) && cpu.mem_read;
    assign data          = data_oe_c ? rdata_q : {DATA_W{1'bz}};
    assign cpu.mem_ready = mem_ready_q;

    always_comb begin
        state_d     = state;
        lat_cnt_d   = lat_cnt;
        rdata_d     = rdata_q;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
`ifdef MEM_BUS_BRIDGE_ALIGN_ERR_EN
        align_err_d = align_err_q;
`endif
        case (state)
            IDLE: begin
                if (hit_c && (cpu.mem_read || cpu.mem_write)) begin
`ifdef MEM_BUS_BRIDGE_ALIGN_ERR_EN
                    if (misalign_c) begin
                        align_err_d = 1'b1;
                        if (cpu.mem_read) begin
                            rdata_d = '0;
                            state_d = RD_DRIVE;
                        end else begin
                            state_d = WR_DONE;
                        end
                    end else
`endif
                    if (cpu.mem_read) begin
                        ram_addr_d = word_c;
                        ram_re_d   = 1'b1;
                        lat_cnt_d  = LAT_W'(RD_LAT - 1);
                        state_d    = RD_WAIT;
                    end else begin
                        ram_addr_d  = word_c;
                        ram_wdata_d = data;
                        ram_we_d    = 1'b1;
                        state_d     = WR_DONE;
                    end
                end
            end
            RD_WAIT: begin
                // An abandoned read still completes so the RAM pipeline stays in step.
                if (lat_cnt == '0) begin
                    rdata_d = ram_rdata;
                    state_d = cpu.mem_read ? RD_DRIVE : IDLE;
                end else begin
                    lat_cnt_d = lat_cnt - LAT_W'(1);
                end
            end
            RD_DRIVE: begin
                if (!cpu.mem_read) state_d = IDLE;
            end
            WR_DONE: begin
                if (!cpu.mem_write) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_BUS_BRIDGE_ALIGN_ERR_EN
        if (state_d == IDLE) align_err_d = 1'b0;
`endif
        mem_ready_d = (state_d == RD_DRIVE) || (state_d == WR_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            rdata_q     <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            mem_ready_q <= 1'b0;
`ifdef MEM_BUS_BRIDGE_ALIGN_ERR_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            lat_cnt     <= lat_cnt_d;
            rdata_q     <= rdata_d;
            ram_addr    <= ram_addr_d;
            ram_wdata   <= ram_wdata_d;
            ram_we      <= ram_we_d;
            ram_re      <= ram_re_d;
            mem_ready_q <= mem_ready_d;
`ifdef MEM_BUS_BRIDGE_ALIGN_ERR_EN
            align_err_q <= align_err_d;
`endif
        end
    end

endmodule
